mpu_hm_bridge: RTL and testbench
================================

# mpu_hm_bridge

Synthesizable responder for the MPU host-memory read port. Accepts a 64-bit read request from `mpu_top` (`hm_addr`/`hm_start`) and performs two 32-bit reads on a word-wide host memory bus with a req/ack handshake. Returns the assembled 64-bit word on `hm_data` with a one-cycle `hm_en` strobe. Replaces the behavioural host-memory model in system builds and reports bus errors and timeouts back to the MPU.

## Interface
- `ADDR_W`, 32: implemented host byte-address width; `hm_addr` bits above it must be zero.
- `TIMEOUT`, 255: cycles a `mem_req` may stay unacknowledged before the read is aborted (1..65535).
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-low reset.
- `hm_addr`  in  64  request byte address from MPU; bits [2:0] ignored.
- `hm_start`  in  1  request strobe, sampled when ready.
- `hm_data`  out  64  read data, little-endian (low word at lower address).
- `hm_en`  out  1  one-cycle strobe: `hm_data`/`hm_err` valid.
- `hm_err`  out  1  qualifies `hm_en`: read failed.
- `busy`  out  1  request in flight; `hm_start` ignored while high.
- `mem_addr`  out  ADDR_W  host bus byte address, word-aligned.
- `mem_req`  out  1  host bus read request, held until ack.
- `mem_ack`  in  1  host bus read complete, `mem_data` valid.
- `mem_data`  in  32  host bus read data.
- `mem_err`  in  1  qualifies `mem_ack`: bus error.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, RESP.
- IDLE: on `hm_start`, latch `{hm_addr[ADDR_W-1:3],3'b0}`.
  - If `hm_addr[63:ADDR_W]` is nonzero, go straight to RESP with error; no bus access.
  - Otherwise go to RD_LO with `mem_addr` = base.
- RD_LO: `mem_req`=1. On `mem_ack` without error, capture `mem_data` into `hm_data[31:0]` and go to RD_HI with `mem_addr` = base+4.
- RD_HI: `mem_req`=1. On `mem_ack` without error, capture into `hm_data[63:32]` and go to RESP.
- RESP: `hm_en`=1 for one cycle, then go to IDLE. An `hm_start` in this cycle is accepted as in IDLE, giving back-to-back requests.
- Errors:
  - `mem_ack`&`mem_err` in RD_LO or RD_HI: the remaining word is skipped.
  - The timeout counter reaches `TIMEOUT` in RD_LO or RD_HI: `mem_req` drops the next cycle.
  - Either case: go to RESP with `hm_err`=1 and `hm_data`=64'hFFFF_FFFF_FFFF_FFFF.
- Timeout counter:
  - Cleared on entry to RD_LO and RD_HI.
  - Increments each cycle `mem_req`=1 and `mem_ack`=0.
  - Saturating, 16 bits.
- Bus rules:
  - `mem_ack` outside RD_LO/RD_HI is ignored.
  - `mem_addr` is stable while `mem_req`=1.
- `hm_start` while `busy` is dropped; it is neither queued nor counted.
- `hm_data` holds its last value between strobes. Captured halves are overwritten only by the next request.
- Base+4 never wraps because the base is 8-byte aligned.

## Timing
- Reset values: `hm_data`=0, `hm_en`=0, `hm_err`=0, `busy`=0, `mem_req`=0, `mem_addr`=0, state IDLE, counter 0.
- Reset asserted mid-transfer:
  - `mem_req` deasserts asynchronously.
  - No `hm_en` is produced.
  - A late `mem_ack` after release is ignored.
- `hm_start` at cycle 0:
  - `busy` and `mem_req` are high from cycle 1.
  - With ack in the same cycle as each req: low ack cycle 1, high req/ack cycle 2, `hm_en` cycle 3. Minimum latency is 3 cycles.
- `busy` is high from the cycle after acceptance through the RESP cycle inclusive.
- Out-of-range request: `hm_en`+`hm_err` at cycle 1.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT` cycles in that state. `hm_en` follows one cycle later.
- All outputs are registered.

## Structure
- Package `mpu_hm_pkg`:
  - FSM state enum.
  - `HM_ERR_DATA` constant (all ones).
  - Host-word width constant (32).
- Sub-module `mpu_hm_timer`:
  - Ports: clear, count enable, `TIMEOUT` compare, `expired` output.
  - Reused by the planned host-memory write path.

## Test plan
- Read `hm_addr`=0x1000; memory returns 0x11223344 at 0x1000 and 0x55667788 at 0x1004, acked immediately -> `hm_en` at cycle 3 with `hm_data`=0x5566778811223344, `hm_err`=0.
- `hm_addr`=0x1005 with acks delayed 4 cycles -> bus reads at 0x1000 then 0x1004; `hm_en` at cycle 11; `mem_addr` stable during each req.
- `hm_addr`=0x1_0000_0000 (ADDR_W=32) -> no `mem_req`; `hm_en`+`hm_err` at cycle 1; `hm_data`=all ones.
- `mem_err` on the low-word ack -> no high-word request; `hm_err`=1, `hm_data`=all ones. Separately, TIMEOUT=8 with no ack -> `mem_req` high 8 cycles, then an error response.
- `hm_start` pulsed while busy is ignored (exactly one response). A new `hm_start` in the RESP cycle starts a second read with `mem_req` on the next cycle.
- Reset asserted in RD_HI -> `mem_req`=0 immediately; all outputs at reset values; a stray `mem_ack` after release gives no `hm_en`.

Source files
------------

// File: rtl/mpu_hm_pkg.sv
// rtl/mpu_hm_pkg.sv - shared types and constants for the MPU host-memory bridge
package mpu_hm_pkg;

  // Read sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_RESP
  } hm_state_e;

  // Host bus word width and the wait-counter width
  localparam int HM_WORD_W = 32;
  localparam int HM_CNT_W  = 16;

  // Data returned with a failed read
  localparam logic [63:0] HM_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mpu_hm_timer.sv
// rtl/mpu_hm_timer.sv - saturating wait counter with timeout compare
module mpu_hm_timer
  import mpu_hm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic [HM_CNT_W-1:0] timeout,
  output logic                expired
);

  logic [HM_CNT_W-1:0] count;
  logic [HM_CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + {{HM_CNT_W{1'b0}}, 1'b1};

  // Fires in the cycle whose increment makes the count reach the limit,
  // so the owner can drop its request on the very next edge
  assign expired = en && !clear && (count_inc >= {1'b0, timeout});

  // Clear has priority; the count sticks at all ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {HM_CNT_W{1'b1}})) begin
      count <= count_inc[HM_CNT_W-1:0];
    end
  end

endmodule

// File: rtl/mpu_hm_bridge.sv
// rtl/mpu_hm_bridge.sv - 64-bit MPU read request to two 32-bit host bus reads
module mpu_hm_bridge
  import mpu_hm_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [63:0]          hm_addr,
  input  logic                 hm_start,
  output logic [63:0]          hm_data,
  output logic                 hm_en,
  output logic                 hm_err,
  output logic                 busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [HM_WORD_W-1:0] mem_data,
  input  logic                 mem_err
);

  hm_state_e            state;
  logic [HM_WORD_W-1:0] lo_word;
  logic [63:0]          hi_mask;
  logic [ADDR_W-1:0]    base_addr;
  logic                 addr_oor;
  logic                 accept;
  logic                 tmr_clear;
  logic                 tmr_en;
  logic                 tmr_expired;

  // Address bits above the implemented width must be zero
  assign hi_mask   = ~((64'd1 << ADDR_W) - 64'd1);
  assign addr_oor  = |(hm_addr & hi_mask);
  assign base_addr = {hm_addr[ADDR_W-1:3], 3'b000};

  // A request is taken in IDLE and also in RESP for back-to-back reads
  assign accept    = hm_start && ((state == ST_IDLE) || (state == ST_RESP));

  // Restart the wait count whenever a new bus word request begins
  assign tmr_clear = (accept && !addr_oor) ||
                     ((state == ST_RD_LO) && mem_ack && !mem_err);
  assign tmr_en    = mem_req && !mem_ack;

  mpu_hm_timer u_timer (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .timeout (HM_CNT_W'(TIMEOUT)),
    .expired (tmr_expired)
  );

  // Read sequencer; every output is a register updated here
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= ST_IDLE;
      lo_word  <= '0;
      hm_data  <= '0;
      hm_en    <= 1'b0;
      hm_err   <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      hm_en <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          mem_req <= 1'b0;
          busy    <= hm_start;
          state   <= ST_IDLE;
          if (hm_start) begin
            if (addr_oor) begin
              state   <= ST_RESP;
              hm_en   <= 1'b1;
              hm_err  <= 1'b1;
              hm_data <= HM_ERR_DATA;
            end else begin
              state    <= ST_RD_LO;
              mem_req  <= 1'b1;
              mem_addr <= base_addr;
            end
          end
        end
        ST_RD_LO: begin
          if ((mem_ack && mem_err) || (!mem_ack && tmr_expired)) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            hm_en   <= 1'b1;
            hm_err  <= 1'b1;
            hm_data <= HM_ERR_DATA;
          end else if (mem_ack) begin
            lo_word  <= mem_data;
            mem_addr <= mem_addr + ADDR_W'(4);
            state    <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if ((mem_ack && mem_err) || (!mem_ack && tmr_expired)) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            hm_en   <= 1'b1;
            hm_err  <= 1'b1;
            hm_data <= HM_ERR_DATA;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            hm_en   <= 1'b1;
            hm_err  <= 1'b0;
            hm_data <= {mem_data, lo_word};
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_hm_bridge.sv
// tb/tb_mpu_hm_bridge.sv - self-checking bench for mpu_hm_bridge
module tb_mpu_hm_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] hm_addr;
  logic        hm_start;
  logic [63:0] hm_data;
  logic        hm_en;
  logic        hm_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last read
  int          o_en_cycle;
  int          o_req_cycles;
  logic [63:0] o_data;
  logic        o_err, o_stable, o_busy_gap, o_req1, o_busy1, o_req_at_en;
  logic [31:0] o_addrs[$];

  mpu_hm_bridge #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst_n),
    .hm_addr  (hm_addr),
    .hm_start (hm_start),
    .hm_data  (hm_data),
    .hm_en    (hm_en),
    .hm_err   (hm_err),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  // Host memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'h1122_3344;
    if (a == 32'h1004) return 32'h5566_7788;
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  // Expected outcome of one read from the transfer rules
  task automatic model(input logic [63:0] addr, input int d, input int err_word, input int noack_word,
                       output int e_en, output logic e_err, output logic [63:0] e_data,
                       output int e_reqs, output int e_naddr);
    logic [31:0] base;
    base   = addr[31:0] & ~32'h7;
    e_err  = 1'b1;
    e_data = '1;
    if (addr[63:32] != 32'h0) begin
      e_en = 1; e_reqs = 0; e_naddr = 0;
    end else if (err_word == 0) begin
      e_en = d + 2; e_reqs = d + 1; e_naddr = 1;
    end else if (noack_word == 0) begin
      e_en = T + 1; e_reqs = T; e_naddr = 1;
    end else if (err_word == 1) begin
      e_en = 2 * d + 3; e_reqs = 2 * d + 2; e_naddr = 2;
    end else if (noack_word == 1) begin
      e_en = d + 2 + T; e_reqs = d + 1 + T; e_naddr = 2;
    end else begin
      e_en = 2 * d + 3; e_reqs = 2 * d + 2; e_naddr = 2;
      e_err = 1'b0; e_data = {mem_word(base + 32'd4), mem_word(base)};
    end
  endtask

  // Issue one request and act as the host memory until hm_en (cycle 0 = start)
  task automatic do_read(input logic [63:0] addr, input int delay, input int err_word,
                         input int noack_word, input int pulse_at, input bit start_now);
    int cyc, age, acked;
    logic [31:0] cur;
    if (!start_now) @(negedge clk);
    hm_addr  = addr;
    hm_start = 1'b1;
    @(negedge clk);
    cyc = 1; age = 0; acked = 0; cur = '0;
    o_en_cycle = -1; o_req_cycles = 0; o_data = '0; o_err = 1'b0; o_stable = 1'b1;
    o_busy_gap = 1'b0; o_req1 = 1'b0; o_busy1 = 1'b0; o_req_at_en = 1'b0;
    o_addrs.delete();
    while (cyc <= 60) begin
      hm_start = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
      if (cyc == 1) begin o_req1 = mem_req; o_busy1 = busy; end
      if (!busy) o_busy_gap = 1'b1;
      if (hm_en) begin
        o_en_cycle = cyc; o_data = hm_data; o_err = hm_err; o_req_at_en = mem_req;
        break;
      end
      if (cyc == pulse_at) begin hm_start = 1'b1; hm_addr = 64'h7770; end
      if (mem_req) begin
        o_req_cycles++;
        if (age == 0) begin o_addrs.push_back(mem_addr); cur = mem_addr; end
        else if (mem_addr !== cur) o_stable = 1'b0;
        if (acked != noack_word && age >= delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          mem_err  = (acked == err_word);
          acked++;
          age = 0;
        end else begin
          age++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    hm_start = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hm_data, hm_en, hm_err, busy, mem_req, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h en=%b err=%b busy=%b req=%b addr=%h, want all zero",
               hm_data, hm_en, hm_err, busy, mem_req, mem_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hm_en, busy, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b busy=%b req=%b, want 000", hm_en, busy, mem_req);
    end
  endtask

  task automatic test_basic();
    do_read(64'h1000, 0, -1, -1, 0, 1'b0);
    n_checks++;
    if (o_en_cycle !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", o_en_cycle); end
    n_checks++;
    if (o_data !== 64'h5566_7788_1122_3344 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_data: got %h err=%b want 5566778811223344 err=0", o_data, o_err);
    end
    n_checks++;
    if (o_req1 !== 1'b1 || o_busy1 !== 1'b1 || o_busy_gap !== 1'b0 || o_req_at_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: got req1=%b busy1=%b gap=%b req_at_en=%b want 1 1 0 0",
               o_req1, o_busy1, o_busy_gap, o_req_at_en);
    end
    n_checks++;
    if (o_addrs.size() != 2 || o_addrs[0] !== 32'h1000 || o_addrs[1] !== 32'h1004) begin
      n_fail++; $display("FAIL basic_addrs: got %p want 1000,1004", o_addrs);
    end
  endtask

  task automatic test_delayed();
    do_read(64'h1005, 4, -1, -1, 0, 1'b0);
    n_checks++;
    if (o_en_cycle !== 11) begin n_fail++; $display("FAIL delayed_latency: got %0d want 11", o_en_cycle); end
    n_checks++;
    if (o_addrs.size() != 2 || o_addrs[0] !== 32'h1000 || o_addrs[1] !== 32'h1004 || o_stable !== 1'b1) begin
      n_fail++; $display("FAIL delayed_addrs: got %p stable=%b want 1000,1004 stable=1", o_addrs, o_stable);
    end
    n_checks++;
    if (o_data !== 64'h5566_7788_1122_3344 || o_req_cycles !== 10) begin
      n_fail++; $display("FAIL delayed_data: got %h reqs=%0d want 5566778811223344 reqs=10", o_data, o_req_cycles);
    end
  endtask

  task automatic test_out_of_range();
    do_read(64'h1_0000_0000, 0, -1, -1, 0, 1'b0);
    n_checks++;
    if (o_en_cycle !== 1 || o_err !== 1'b1 || o_data !== '1) begin
      n_fail++; $display("FAIL oor_response: got cyc=%0d err=%b data=%h want 1 1 all-ones", o_en_cycle, o_err, o_data);
    end
    n_checks++;
    if (o_req_cycles !== 0 || o_req1 !== 1'b0) begin
      n_fail++; $display("FAIL oor_no_bus: got reqs=%0d want 0", o_req_cycles);
    end
  endtask

  task automatic test_errors();
    do_read(64'h2040, 1, 0, -1, 0, 1'b0);
    n_checks++;
    if (o_en_cycle !== 3 || o_err !== 1'b1 || o_data !== '1 || o_addrs.size() != 1 || o_req_cycles !== 2) begin
      n_fail++;
      $display("FAIL bus_error: got cyc=%0d err=%b data=%h naddr=%0d reqs=%0d want 3 1 all-ones 1 2",
               o_en_cycle, o_err, o_data, o_addrs.size(), o_req_cycles);
    end
    do_read(64'h2080, 0, -1, 0, 0, 1'b0);
    n_checks++;
    if (o_req_cycles !== T || o_en_cycle !== T + 1 || o_err !== 1'b1 || o_data !== '1 || o_req_at_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got reqs=%0d cyc=%0d err=%b data=%h want %0d %0d 1 all-ones",
               o_req_cycles, o_en_cycle, o_err, o_data, T, T + 1);
    end
  endtask

  task automatic test_busy_ignored();
    int extra;
    do_read(64'h3000, 2, -1, -1, 2, 1'b0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (hm_en || mem_req) extra++;
    end
    n_checks++;
    if (o_en_cycle !== 7 || o_data !== {mem_word(32'h3004), mem_word(32'h3000)} || extra !== 0) begin
      n_fail++;
      $display("FAIL busy_ignored: got cyc=%0d data=%h extra=%0d want 7 %h 0",
               o_en_cycle, o_data, extra, {mem_word(32'h3004), mem_word(32'h3000)});
    end
  endtask

  task automatic test_back_to_back();
    do_read(64'h4000, 1, -1, -1, 0, 1'b0);
    do_read(64'h4108, 0, -1, -1, 0, 1'b1);
    n_checks++;
    if (o_req1 !== 1'b1 || o_busy1 !== 1'b1 || o_en_cycle !== 3) begin
      n_fail++; $display("FAIL back_to_back: got req1=%b busy1=%b cyc=%0d want 1 1 3", o_req1, o_busy1, o_en_cycle);
    end
    n_checks++;
    if (o_data !== {mem_word(32'h410C), mem_word(32'h4108)} || o_err !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back_data: got %h want %h", o_data, {mem_word(32'h410C), mem_word(32'h4108)});
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    hm_addr = 64'h5000; hm_start = 1'b1;
    @(negedge clk);
    hm_start = 1'b0;
    mem_ack = 1'b1; mem_data = 32'hCAFE_0001; mem_err = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h5004) begin
      n_fail++; $display("FAIL reset_mid_pre: got req=%b addr=%h want 1 5004", mem_req, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_async_req: got %b want 0", mem_req); end
    n_checks++;
    if ({hm_data, hm_en, hm_err, busy, mem_addr} !== '0) begin
      n_fail++; $display("FAIL reset_mid_values: got data=%h en=%b err=%b busy=%b addr=%h want zero",
                         hm_data, hm_en, hm_err, busy, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (hm_en || mem_req || busy) stray++;
    end
    mem_ack = 1'b0;
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL late_ack_ignored: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [63:0] addr, e_data;
      logic        e_err;
      int          d, m, ew, nw, e_en, e_reqs, e_naddr;
      logic [31:0] base;
      addr = {32'h0, $urandom()};
      if ($urandom_range(0, 5) == 0) addr[32 + $urandom_range(0, 31)] = 1'b1;
      d  = $urandom_range(0, 5);
      m  = $urandom_range(0, 7);
      ew = (m == 0) ? 0 : (m == 1) ? 1 : -1;
      nw = (m == 2) ? 0 : (m == 3) ? 1 : -1;
      model(addr, d, ew, nw, e_en, e_err, e_data, e_reqs, e_naddr);
      do_read(addr, d, ew, nw, 0, 1'b0);
      base = addr[31:0] & ~32'h7;
      n_checks++;
      if (o_en_cycle !== e_en || o_err !== e_err || o_data !== e_data) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: got cyc=%0d err=%b data=%h want %0d %b %h",
                 i, o_en_cycle, o_err, o_data, e_en, e_err, e_data);
      end
      n_checks++;
      if (o_req_cycles !== e_reqs || o_addrs.size() != e_naddr || o_stable !== 1'b1 ||
          o_busy_gap !== 1'b0 || o_req_at_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: got reqs=%0d naddr=%0d stable=%b gap=%b want %0d %0d 1 0",
                 i, o_req_cycles, o_addrs.size(), o_stable, o_busy_gap, e_reqs, e_naddr);
      end
      for (int k = 0; k < e_naddr && k < o_addrs.size(); k++) begin
        n_checks++;
        if (o_addrs[k] !== base + 32'(4 * k)) begin
          n_fail++; $display("FAIL rand_addr[%0d.%0d]: got %h want %h", i, k, o_addrs[k], base + 32'(4 * k));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hm_addr = '0; hm_start = 1'b0;
    mem_ack = 1'b0; mem_data = '0; mem_err = 1'b0;
    test_reset();
    test_basic();
    test_delayed();
    test_out_of_range();
    test_errors();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
